// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - byte-strobed register file with NUM_RD read ports and reset clear sweep
// Optional macro REG_FILE_PARAM_ZERO_REG_EN hardwires address 0 to zero.
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic                     busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
`ifdef REG_FILE_PARAM_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_word;
  logic              wr_en;

  assign busy  = (state == CLEAR);
  assign wr_en = we && !busy && !(ZERO_REG && (wa == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == CLEAR) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == LAST) begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    end
  end

  // Post-write word: strobed bytes from wd, the rest from the current entry
  always_comb begin
    wr_word = mem[wa];
    for (int k = 0; k < NB; k++) begin
      if (wstrb[k]) wr_word[k*8 +: 8] = wd[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wr_word;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      if (busy || (ZERO_REG && (ra_i == '0))) begin
        rd_i = '0;
      end else if (wr_en && (ra_i == wa)) begin
        rd_i = wr_word;
      end else begin
        rd_i = mem[ra_i];
      end
    end

    assign rd[i*DATA_W +: DATA_W] = rd_i;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
// Expectations for address 0 follow REG_FILE_PARAM_ZERO_REG_EN.
module tb_reg_file_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [DATA_W/8-1:0]      wstrb;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .wstrb(wstrb), .ra(ra), .rd(rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input string name, input logic [31:0] exp0, input logic [31:0] exp1);
    #1;
    checks++;
    if (rd[31:0] !== exp0 || rd[63:32] !== exp1) begin
      errors++;
      $display("FAIL %s: rd0=%h rd1=%h expected rd0=%h rd1=%h", name, rd[31:0], rd[63:32], exp0, exp1);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; wa = a; wd = d; wstrb = s;
    tick();
    we = 1'b0; wstrb = 4'h0;
  endtask

  // Checks busy before each of the 32 sweep edges, then busy low after the last
  task automatic expect_sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || rd !== '0) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b rd=%h expected busy=1 rd=0", name, i, busy, rd);
      end
      tick();
    end
    we = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    we = 1'b0; wa = '0; wd = '0; wstrb = '0; ra = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rd=%h expected busy=1 rd=0", busy, rd);
    end
    expect_sweep("reset_sweep");
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      check_rd("reset_entry", 32'h0, 32'h0);
    end
  endtask

  task automatic test_write_read;
    do_write(5'd1, 32'h0123_4567, 4'hF);
    do_write(5'd2, 32'h89AB_CDEF, 4'hF);
    do_write(5'd31, 32'hFFFF_0000, 4'hF);
    ra = {5'd2, 5'd1};
    check_rd("read_1_2", 32'h0123_4567, 32'h89AB_CDEF);
    ra = {5'd1, 5'd31};
    check_rd("read_31_1", 32'hFFFF_0000, 32'h0123_4567);
    ra = {5'd31, 5'd31};
    check_rd("read_same_addr", 32'hFFFF_0000, 32'hFFFF_0000);
  endtask

  task automatic test_byte_strobe;
    do_write(5'd3, 32'hAABB_CCDD, 4'hF);
    do_write(5'd3, 32'h1122_3344, 4'b0101);
    ra = {5'd3, 5'd3};
    check_rd("byte_strobe", 32'hAA22_CC44, 32'hAA22_CC44);
    do_write(5'd3, 32'h0000_0000, 4'b0000);
    check_rd("zero_strobe", 32'hAA22_CC44, 32'hAA22_CC44);
  endtask

  task automatic test_bypass;
    ra = {5'd7, 5'd7};
    we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF; wstrb = 4'hF;
    check_rd("bypass_full", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    we = 1'b0; wstrb = 4'h0;
    check_rd("bypass_stored", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ra = {5'd3, 5'd7};
    we = 1'b1; wa = 5'd7; wd = 32'h5500_0000; wstrb = 4'b1000;
    check_rd("bypass_partial", 32'h55AD_BEEF, 32'hAA22_CC44);
    tick();
    we = 1'b0; wstrb = 4'h0;
    check_rd("bypass_partial_stored", 32'h55AD_BEEF, 32'hAA22_CC44);
  endtask

  task automatic test_zero_reg;
    logic [31:0] exp;
`ifdef REG_FILE_PARAM_ZERO_REG_EN
    exp = 32'h0;
`else
    exp = 32'hFFFF_FFFF;
`endif
    ra = {5'd0, 5'd0};
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; wstrb = 4'hF;
    check_rd("zero_reg_bypass", exp, exp);
    tick();
    we = 1'b0; wstrb = 4'h0;
    check_rd("zero_reg_stored", exp, exp);
  endtask

  task automatic test_busy_write;
    do_write(5'd5, 32'hCAFE_F00D, 4'hF);
    do_write(5'd9, 32'h0BAD_CAFE, 4'hF);
    // rst wins over a simultaneous write, then writes during the sweep are dropped
    rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h9999_9999; wstrb = 4'hF;
    tick();
    rst = 1'b0; wa = 5'd5; wd = 32'h1234_5678; ra = {5'd5, 5'd5};
    expect_sweep("busy_write_sweep");
    wstrb = 4'h0;
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a)};
      check_rd("cleared_entry", 32'h0, 32'h0);
    end
  endtask

  task automatic test_mid_sweep;
    do_write(5'd12, 32'h1357_9BDF, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra = {5'd12, 5'd12};
    expect_sweep("mid_sweep_restart");
    check_rd("mid_sweep_entry", 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; wstrb = '0; ra = '0;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_bypass();
    test_zero_reg();
    test_busy_write();
    test_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 32, giving the register width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have a parameter ADDR_W, default 5, giving the address width; depth DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have a parameter NUM_RD, default 2, giving the number of read ports (1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port wa, input, ADDR_W bits: write address.
REQ-008 The block SHALL have port wd, input, DATA_W bits: write data.
REQ-009 The block SHALL have port wstrb, input, DATA_W/8 bits: byte write mask, bit k enabling byte k.
REQ-010 The block SHALL have port ra, input, NUM_RD*ADDR_W bits: read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rd, output, NUM_RD*DATA_W bits: read data, port i at bits [i*DATA_W +: DATA_W].
REQ-012 The block SHALL have port busy, output, 1 bit: clear sweep in progress.

Function
REQ-013 Reads SHALL be combinational with zero latency: rd_i = mem[ra_i], merged with any bypass per REQ-016.
REQ-014 On a rising edge with we=1 and busy=0, each byte k of mem[wa] with wstrb[k]=1 SHALL take wd byte k; the other bytes SHALL hold.
REQ-015 we=1 with wstrb=0 SHALL leave the array unchanged.
REQ-016 Write-through bypass: while we=1, busy=0 and ra_i==wa, rd_i SHALL show the post-write value (strobed bytes from wd, other bytes from mem) in the same cycle.
REQ-017 All read ports SHALL be independent; any read ports may use the same address at once and each returns identical data.
REQ-018 The FSM SHALL have two states: IDLE and CLEAR.
REQ-019 In CLEAR each rising edge SHALL write 0 to mem[ptr] and increment ptr; at ptr==DEPTH-1 that write completes and the state goes to IDLE.
REQ-020 busy SHALL be 1 exactly while the state is CLEAR.
REQ-021 While busy=1, all rd_i SHALL read 0, and we/wstrb SHALL be ignored with no write and no bypass.
REQ-022 ptr SHALL be ADDR_W bits wide and SHALL NOT wrap while in IDLE.

Reset
REQ-023 A rising edge with rst=1 SHALL set state=CLEAR and ptr=0, so busy=1 after that edge and rd=0.
REQ-024 While rst is held at 1, the block SHALL stay in CLEAR with ptr=0, and mem[0] SHALL be written with 0 on each edge.
REQ-025 After rst falls, exactly DEPTH further edges SHALL complete the sweep; busy SHALL then fall and every entry reads 0.
REQ-026 rst asserted in mid-sweep SHALL restart the sweep from ptr=0.
REQ-027 rst SHALL take priority over we in the same cycle.

Configuration
REQ-028 With macro REG_FILE_PARAM_ZERO_REG_EN defined, address 0 SHALL be hardwired: writes to wa=0 are discarded, rd_i for ra_i=0 is always 0, and no bypass applies for address 0.
REQ-029 With REG_FILE_PARAM_ZERO_REG_EN undefined, address 0 SHALL be an ordinary register.

Verification
REQ-030 Reset sweep: rst=1 for 1 cycle, defaults -> busy=1 for 32 cycles after rst falls, then busy=0, and all 32 entries read 0x00000000.
REQ-031 Byte strobe: mem[3]=0xAABBCCDD, write wa=3, wd=0x11223344, wstrb=4'b0101 -> mem[3]=0xAA22CC44.
REQ-032 Bypass: we=1, wa=7, wd=0xDEADBEEF, wstrb=4'hF, ra0=7, ra1=7 -> rd0=rd1=0xDEADBEEF in the same cycle, before the edge.
REQ-033 Write during busy: we=1, wa=5, wd=0x12345678 while busy=1 -> rd=0 during the sweep, and mem[5]=0 after busy falls.
REQ-034 Mid-sweep reset: rst=1 again at sweep cycle 10 -> busy stays 1 for 32 more cycles after rst falls.
REQ-035 Zero register (macro defined): write wa=0, wd=0xFFFFFFFF -> rd for ra=0 is 0 in the same cycle and after the edge; with the macro undefined it reads 0xFFFFFFFF.
